piano_play_controller: RTL and testbench



---
 rtl/piano_play_controller_if.sv | 31 +++
 rtl/piano_play_controller.sv | 156 +++++++++++++++
 tb/tb_piano_play_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/piano_play_controller_if.sv
// Note path bundle between the piano play controller, the song ROM,
// the keyboard decoder and the buzzer. The controller takes the master side.
interface piano_play_controller_if;
    logic [3:0] key_note;
    logic       auto_req;
    logic [3:0] song_note;
    logic [4:0] song_addr;
    logic [3:0] note_out;
    logic       note_valid;
    logic [1:0] mode;

    modport master (
        input  key_note,
        input  auto_req,
        input  song_note,
        output song_addr,
        output note_out,
        output note_valid,
        output mode
    );

    modport slave (
        output key_note,
        output auto_req,
        output song_note,
        input  song_addr,
        input  note_out,
        input  note_valid,
        input  mode
    );
endinterface

// File: rtl/piano_play_controller.sv
// Piano note path sequencer: debounces the keyboard note, arbitrates it
// against a ROM-driven auto-play sequencer (keyboard always wins) and
// drives one registered note index to the tone generator.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | silent, waiting for a debounced key or an auto-play request
// LIVE  | note_out follows the debounced key until it is released
// AUTO  | stepping song_addr once per beat, note_out follows the ROM
module piano_play_controller #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int BEAT_CYCLES     = 50
) (
    input  logic clk,
    input  logic rst_n,
    piano_play_controller_if.master bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BT_W = $clog2(BEAT_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BT_W-1:0] BT_LAST   = BT_W'(BEAT_CYCLES - 1);
    localparam logic [3:0]      NOTE_NONE = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LIVE = 2'b01,
        AUTO = 2'b10
    } state_t;

    // Only 1..7 are playable; every other code (rest, illegal, marker) is silence.
    function automatic logic [3:0] note_map(input logic [3:0] n);
        return (n >= 4'd1 && n <= 4'd7) ? n : NOTE_NONE;
    endfunction

    logic [3:0]      key_sync;
    logic [3:0]      candidate;
    logic [3:0]      key_stable;
    logic [DB_W-1:0] db_count;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      note_q;
    logic [3:0]      note_nxt;
    logic            valid_q;
    logic [4:0]      addr_q;
    logic [4:0]      addr_nxt;
    logic [BT_W-1:0] beat_q;
    logic [BT_W-1:0] beat_nxt;

    logic key_pressed;
    logic song_end;

    // Register the raw key code first (it comes from another clock-free decoder),
    // then accept it only after DEBOUNCE_CYCLES identical consecutive samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_sync   <= NOTE_NONE;
            candidate  <= NOTE_NONE;
            key_stable <= NOTE_NONE;
            db_count   <= '0;
        end else begin
            key_sync <= note_map(bus.key_note);
            if (key_sync != candidate) begin
                candidate <= key_sync;
                db_count  <= '0;
            end else if (db_count == DB_LAST) begin
                key_stable <= candidate;
            end else begin
                db_count <= db_count + 1'b1;
            end
        end
    end

    // key_stable only ever holds 1..7 or 15, so anything but 15 is a press.
    assign key_pressed = (key_stable != NOTE_NONE);
    assign song_end    = (bus.song_note == 4'd15);

    // State register together with the registered outputs it qualifies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            note_q  <= NOTE_NONE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state   <= state_nxt;
            note_q  <= note_nxt;
            valid_q <= (note_nxt != NOTE_NONE);
            addr_q  <= addr_nxt;
            beat_q  <= beat_nxt;
        end
    end

    // Next-state arbitration: a debounced key beats both auto_req and the end marker.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (key_pressed) begin
                    state_nxt = LIVE;
                end else if (bus.auto_req) begin
                    state_nxt = AUTO;
                end
            end
            LIVE: begin
                if (!key_pressed) begin
                    state_nxt = IDLE;
                end
            end
            AUTO: begin
                if (key_pressed) begin
                    state_nxt = LIVE;
                end else if (song_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next output values; entering AUTO starts from address 0, beat 0, silent,
    // and song_addr is parked at 0 whenever the sequencer is not playing.
    always_comb begin
        note_nxt = NOTE_NONE;
        addr_nxt = '0;
        beat_nxt = '0;
        case (state_nxt)
            LIVE: begin
                note_nxt = key_stable;
            end
            AUTO: begin
                if (state == AUTO) begin
                    note_nxt = note_map(bus.song_note);
                    if (beat_q == BT_LAST) begin
                        beat_nxt = '0;
                        addr_nxt = addr_q + 1'b1;
                    end else begin
                        beat_nxt = beat_q + 1'b1;
                        addr_nxt = addr_q;
                    end
                end
            end
            default: begin
                note_nxt = NOTE_NONE;
            end
        endcase
    end

    assign bus.mode       = state;
    assign bus.note_out   = note_q;
    assign bus.note_valid = valid_q;
    assign bus.song_addr  = addr_q;

endmodule

// File: tb/tb_piano_play_controller.sv
// Self-checking bench for piano_play_controller with short debounce/beat
// parameters, a behavioural song ROM and an arithmetic expectation model.
module tb_piano_play_controller;

    localparam int DB   = 4;
    localparam int BEAT = 8;
    localparam int LAT  = DB + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] rom [32];

    always #5 clk = ~clk;

    piano_play_controller_if bus_if ();

    assign bus_if.song_note = rom[bus_if.song_addr];

    piano_play_controller #(
        .DEBOUNCE_CYCLES (DB),
        .BEAT_CYCLES     (BEAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int m, input int n, input int a);
        chk({tag, ".mode"},  int'(bus_if.mode),       m);
        chk({tag, ".note"},  int'(bus_if.note_out),   n);
        chk({tag, ".valid"}, int'(bus_if.note_valid), (n != 15) ? 1 : 0);
        chk({tag, ".addr"},  int'(bus_if.song_addr),  a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int play_map(input int n);
        return (n >= 1 && n <= 7) ? n : 15;
    endfunction

    function automatic int find_marker();
        for (int i = 0; i < 32; i++) begin
            if (rom[i] == 4'd15) return i;
        end
        return -1;
    endfunction

    // Expected outputs k edges after the AUTO entry edge (k = 0 is the entry edge).
    task automatic auto_exp(input int k, input int marker,
                            output int m, output int n, output int a);
        if (marker >= 0 && k > BEAT * marker) begin
            m = 0; n = 15; a = 0;
        end else begin
            m = 2;
            a = (k / BEAT) % 32;
            n = (k == 0) ? 15 : play_map(int'(rom[((k - 1) / BEAT) % 32]));
        end
    endtask

    // Start auto-play from IDLE, check `cycles` edges, optionally poke auto_req at edge req_at.
    task automatic run_auto(input string tag, input int cycles, input int req_at);
        int m, n, a, marker;
        marker = find_marker();
        bus_if.auto_req = 1'b1;
        tick();
        bus_if.auto_req = 1'b0;
        auto_exp(0, marker, m, n, a);
        chk_out({tag, "_entry"}, m, n, a);
        for (int k = 1; k <= cycles; k++) begin
            bus_if.auto_req = (k == req_at);
            tick();
            auto_exp(k, marker, m, n, a);
            chk_out($sformatf("%s_k%0d", tag, k), m, n, a);
        end
        bus_if.auto_req = 1'b0;
    endtask

    initial begin
        int kp, len, k0, pos, m, n, a, marker;

        for (int i = 0; i < 32; i++) rom[i] = 4'd0;

        // Reset overrides inputs that would otherwise start something.
        rst_n = 1'b0;
        bus_if.key_note = 4'd3;
        bus_if.auto_req = 1'b1;
        tick();
        tick();
        chk_out("reset", 0, 15, 0);
        rst_n = 1'b1;
        bus_if.key_note = 4'd15;
        bus_if.auto_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("post_reset", 0, 15, 0);
        end

        // Live press and release latency; first pass also collides auto_req with the press.
        for (int it = 0; it < 4; it++) begin
            kp = (it == 0) ? 5 : int'($urandom_range(1, 7));
            bus_if.key_note = 4'(kp);
            for (int e = 0; e <= LAT + 1; e++) begin
                bus_if.auto_req = (it == 0 && e == LAT);
                tick();
                if (e >= LAT) chk_out($sformatf("press%0d_e%0d", it, e), 1, kp, 0);
                else          chk_out($sformatf("press%0d_e%0d", it, e), 0, 15, 0);
            end
            bus_if.auto_req = 1'b0;
            bus_if.key_note = (it == 3) ? 4'($urandom_range(8, 14)) : 4'd15;
            for (int e = 0; e <= LAT + 1; e++) begin
                tick();
                if (e >= LAT) chk_out($sformatf("release%0d_e%0d", it, e), 0, 15, 0);
                else          chk_out($sformatf("release%0d_e%0d", it, e), 1, kp, 0);
            end
        end
        bus_if.key_note = 4'd15;

        // Bounce: 2/15 every two cycles, then random sub-threshold glitches.
        for (int c = 0; c < 40; c++) begin
            bus_if.key_note = ((c / 2) % 2 == 0) ? 4'd2 : 4'd15;
            tick();
            chk_out($sformatf("bounce_c%0d", c), 0, 15, 0);
        end
        for (int r = 0; r < 16; r++) begin
            len = int'($urandom_range(1, DB - 1));
            bus_if.key_note = (r % 2 == 0) ? 4'($urandom_range(1, 7)) : 4'd15;
            for (int c = 0; c < len; c++) begin
                tick();
                chk_out($sformatf("glitch_r%0d", r), 0, 15, 0);
            end
        end
        bus_if.key_note = 4'd15;
        for (int c = 0; c <= LAT; c++) begin
            tick();
            chk_out("settle", 0, 15, 0);
        end

        // Directed song {1,2,0,3,15}.
        for (int i = 0; i < 32; i++) rom[i] = 4'd0;
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd0; rom[3] = 4'd3; rom[4] = 4'd15;
        run_auto("song_a", BEAT * 4 + 6, 13);

        // Random songs with random rests/illegal codes and a stray auto_req mid-song.
        for (int s = 0; s < 3; s++) begin
            pos = int'($urandom_range(1, 6));
            for (int i = 0; i < 32; i++) rom[i] = 4'($urandom_range(0, 14));
            rom[pos] = 4'd15;
            run_auto($sformatf("song_r%0d", s), BEAT * pos + 4, int'($urandom_range(1, BEAT * pos)));
        end

        // Preempt during song_addr=2, then auto_req during LIVE is ignored.
        for (int i = 0; i < 32; i++) rom[i] = 4'((i % 7) + 1);
        rom[20] = 4'd15;
        marker = find_marker();
        kp = int'($urandom_range(1, 7));
        k0 = int'($urandom_range(2 * BEAT, 3 * BEAT - 1));
        bus_if.auto_req = 1'b1;
        tick();
        bus_if.auto_req = 1'b0;
        for (int k = 1; k <= k0; k++) begin
            tick();
            auto_exp(k, marker, m, n, a);
            chk_out($sformatf("pre_k%0d", k), m, n, a);
        end
        bus_if.key_note = 4'(kp);
        for (int j = 1; j <= LAT + 1; j++) begin
            tick();
            if (j <= LAT) begin
                auto_exp(k0 + j, marker, m, n, a);
                chk_out($sformatf("preempt_j%0d", j), m, n, a);
            end else begin
                chk_out("preempt_live", 1, kp, 0);
            end
        end
        bus_if.auto_req = 1'b1;
        tick();
        bus_if.auto_req = 1'b0;
        chk_out("live_req", 1, kp, 0);
        tick();
        chk_out("live_req_after", 1, kp, 0);
        bus_if.key_note = 4'd15;
        for (int e = 0; e <= LAT + 3; e++) begin
            tick();
            if (e >= LAT) chk_out($sformatf("back_idle_e%0d", e), 0, 15, 0);
            else          chk_out($sformatf("back_idle_e%0d", e), 1, kp, 0);
        end

        // Wrap 31 -> 0 with a marker-free ROM, then reset mid-beat.
        for (int i = 0; i < 32; i++) rom[i] = 4'd1;
        run_auto("wrap", BEAT * 32 + 20, -1);
        rst_n = 1'b0;
        bus_if.key_note = 4'd4;
        tick();
        chk_out("reset_mid_song", 0, 15, 0);
        rst_n = 1'b1;
        bus_if.key_note = 4'd15;
        for (int e = 0; e < LAT + 1; e++) begin
            tick();
            chk_out("after_song_reset", 0, 15, 0);
        end

        // Reset mid-debounce restarts the full acceptance latency.
        bus_if.key_note = 4'd6;
        for (int e = 0; e < 4; e++) tick();
        rst_n = 1'b0;
        tick();
        chk_out("reset_mid_db", 0, 15, 0);
        rst_n = 1'b1;
        for (int e = 0; e <= LAT; e++) begin
            tick();
            if (e >= LAT) chk_out($sformatf("db_restart_e%0d", e), 1, 6, 0);
            else          chk_out($sformatf("db_restart_e%0d", e), 0, 15, 0);
        end
        bus_if.key_note = 4'd15;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
